// File: rtl/dms_pkg.sv
// Shared types and constants for the data memory system.
// Optional perf counters are enabled by DMS_PERF_CNT_EN.
package dms_pkg;

  localparam int ADDR_W      = 10;
  localparam int TAG_W       = 3;
  localparam int IDX_W       = 5;
  localparam int OFF_W       = 2;
  localparam int DATA_W      = 32;
  localparam int LINES       = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int MEM_WORDS   = 1024;
  localparam int BLK_W       = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE
  } state_t;

  typedef logic [BLOCK_WORDS-1:0][DATA_W-1:0] block_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    block_t           data;
  } line_t;

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(
    input logic [ADDR_W-1:0] a
  );
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] off_of(
    input logic [ADDR_W-1:0] a
  );
    return a[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/dms_main_mem.sv
// 1024 x 32 backing store: 4-word block read, 1-word write.
// Not reset; contents rely on the RAM's zero power-up state.
import dms_pkg::*;

module dms_main_mem (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BLK_W-1:0]  baddr,
  output block_t            block
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    block = '0;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      block[w] = mem[{baddr, OFF_W'(w)}];
    end
  end

endmodule

// File: rtl/data_memory_system.sv
// Direct-mapped write-through, no-write-allocate data cache.
// DMS_PERF_CNT_EN adds read hit/miss counters.
import dms_pkg::*;

module data_memory_system #(
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] word_address,
  input  logic [DATA_W-1:0] data_in,
  output logic              stall,
  output logic [DATA_W-1:0] data_out
`ifdef DMS_PERF_CNT_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  line_t             lines [LINES];

  line_t             cur;
  logic              hit;
  logic              idle;
  logic              rd_req;
  logic              start_refill;
  logic              start_write;
  logic              last;

  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  line_t             c_line;
  logic              c_hit;
  logic              do_refill;
  logic              do_write;
  block_t            blk;

  assign cur    = lines[idx_of(word_address)];
  assign hit    = cur.valid && (cur.tag == tag_of(word_address));
  assign idle   = (state == S_IDLE);
  assign rd_req = mem_read && !mem_write;

  assign start_refill = idle && rd_req && !hit;
  assign start_write  = idle && mem_write;

  // With a 1-cycle latency the commit happens on the request edge itself.
  assign last   = idle ? (MEM_LATENCY == 1) : (cnt == LAST);
  assign c_addr = idle ? word_address : lat_addr;
  assign c_data = idle ? data_in : lat_data;

  assign c_line = lines[idx_of(c_addr)];
  assign c_hit  = c_line.valid && (c_line.tag == tag_of(c_addr));

  assign do_refill = rst && last &&
                     (start_refill || state == S_REFILL);
  assign do_write  = rst && last &&
                     (start_write || state == S_WRITE);

  dms_main_mem u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (c_addr),
    .wdata (c_data),
    .baddr (c_addr[ADDR_W-1:OFF_W]),
    .block (blk)
  );

  assign stall = rst &&
                 (!idle || start_refill || start_write);

  assign data_out = (rst && idle && rd_req && hit)
                    ? cur.data[off_of(word_address)]
                    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      for (int i = 0; i < LINES; i++) begin
        lines[i].valid <= 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_write || start_refill) begin
            lat_addr <= word_address;
            lat_data <= data_in;
            cnt      <= 4'd1;
            if (!last) begin
              state <= start_write ? S_WRITE : S_REFILL;
            end
          end
        end
        S_REFILL,
        S_WRITE: begin
          if (last) state <= S_IDLE;
          else      cnt   <= cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase

      if (do_refill) begin
        lines[idx_of(c_addr)].valid <= 1'b1;
        lines[idx_of(c_addr)].tag   <= tag_of(c_addr);
        lines[idx_of(c_addr)].data  <= blk;
      end

      if (do_write && c_hit) begin
        lines[idx_of(c_addr)].data[off_of(c_addr)] <= c_data;
      end
    end
  end

`ifdef DMS_PERF_CNT_EN
  logic rehit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      rehit      <= 1'b0;
    end else begin
      rehit <= do_refill;
      if (idle && rd_req) begin
        if (hit) begin
          // The held request right after a refill is the same access.
          if (!(rehit && word_address == lat_addr) &&
              hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
          end
        end else if (miss_count != 16'hFFFF) begin
          miss_count <= miss_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_system.sv
// Directed scoreboard bench for data_memory_system.
// Default build: MEM_LATENCY = 4, perf counters absent.
module tb_data_memory_system;

  localparam int LAT = 4;

  typedef struct {
    int          stalls;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [9:0]  word_address = '0;
  logic [31:0] data_in = '0;
  logic        stall;
  logic [31:0] data_out;

  int   errors = 0;
  int   checks = 0;
  exp_t sb [$];

  data_memory_system #(.MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .word_address (word_address),
    .data_in      (data_in),
    .stall        (stall),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  // Drive one request, count stall cycles, then score it.
  task automatic op(input string tag,
                    input logic rd, input logic wr,
                    input logic [9:0] a,
                    input logic [31:0] d,
                    input int exp_stalls,
                    input logic [31:0] exp_data);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    mem_read     = rd;
    mem_write    = wr;
    word_address = a;
    data_in      = d;
    sb.push_back('{exp_stalls, wr ? 32'h0 : exp_data});
    n = 0;
    @(negedge clk);
    while (stall && n < 50) begin
      n++;
      @(posedge clk); #1;
      if (wr) begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({tag, ".stalls"}, 32'(n), 32'(e.stalls));
    chk({tag, ".data"}, data_out, e.data);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.data", data_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle.stall", 32'(stall), 32'h0);

    op("rd004_cold", 1, 0, 10'h004, 0, LAT, 32'h0);
    op("wr004", 0, 1, 10'h004, 32'hDEADBEEF, LAT, 0);
    op("rd004_hit", 1, 0, 10'h004, 0, 0, 32'hDEADBEEF);

    op("wr008", 0, 1, 10'h008, 32'hCAFEBABE, LAT, 0);
    op("rd008_miss", 1, 0, 10'h008, 0, LAT, 32'hCAFEBABE);
    op("rd009_hit", 1, 0, 10'h009, 0, 0, 32'h0);

    op("rd004_again", 1, 0, 10'h004, 0, 0, 32'hDEADBEEF);
    op("rd104_conf", 1, 0, 10'h104, 0, LAT, 32'h0);
    op("rd004_evict", 1, 0, 10'h004, 0, LAT, 32'hDEADBEEF);

    op("rdwr010", 1, 1, 10'h010, 32'h12345678, LAT, 0);
    op("rd010", 1, 0, 10'h010, 0, LAT, 32'h12345678);

    // Reset during the second stall cycle of a write.
    @(posedge clk); #1;
    mem_write    = 1'b1;
    word_address = 10'h020;
    data_in      = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(negedge clk);
    chk("abort.pre_stall", 32'(stall), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort.stall", 32'(stall), 32'h0);
    chk("abort.data", data_out, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    op("rd020_abort", 1, 0, 10'h020, 0, LAT, 32'h0);
    op("rd004_post_rst", 1, 0, 10'h004, 0, LAT, 32'hDEADBEEF);

    chk("sb.empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
